// File: rtl/load_store_unit_if.sv
// Word-addressed 64-bit data-memory port between the load/store unit (master)
// and data memory (slave): request/ready handshake with byte strobes.
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ready;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: issues one outstanding access at a time,
// stalls the pipeline while it waits, and produces the MEM/WB register contents.
module load_store_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_valid,
  input  logic              exmem_read,
  input  logic              exmem_write,
  input  logic [63:0]       exmem_addr,
  input  logic [63:0]       exmem_wdata,
  input  logic [1:0]        exmem_size,
  input  logic              exmem_unsigned,
  input  logic [4:0]        exmem_rd,
  output logic              stall,
  load_store_unit_if.master mem,
  output logic              memwb_valid,
  output logic [63:0]       memwb_readdata,
  output logic [4:0]        memwb_rd,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] w, input logic [1:0] sz,
                                              input logic uns);
    case (sz)
      2'd0:    return uns ? {56'd0, w[7:0]}  : {{56{w[7]}}, w[7:0]};
      2'd1:    return uns ? {48'd0, w[15:0]} : {{48{w[15]}}, w[15:0]};
      2'd2:    return uns ? {32'd0, w[31:0]} : {{32{w[31]}}, w[31:0]};
      default: return w;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               req_q, we_q, load_q, uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [63:0]        wdata_q;
  logic [7:0]         wmask_q;
  logic [2:0]         off_q;
  logic [1:0]         size_q;
  logic [4:0]         rd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               memwb_valid_q, fault_q;
  logic [63:0]        readdata_q;
  logic [4:0]         memwb_rd_q;
  logic [1:0]         cause_q;

  logic mem_op, illegal, misalign, accept, done_ok, timeout_hit;
  logic unused_addr_hi;

  assign unused_addr_hi = ^exmem_addr[63:ADDR_W+3];

  always_comb begin
    mem_op      = exmem_valid && (exmem_read || exmem_write);
    illegal     = exmem_valid && exmem_read && exmem_write;
    misalign    = |(exmem_addr[2:0] & align_mask(exmem_size));
    accept      = (state_q == IDLE) && mem_op && !illegal && !misalign;
    done_ok     = (state_q == WAIT) && mem.mem_ready;
    // Ready arriving in the last allowed cycle takes priority over the timeout.
    timeout_hit = (state_q == WAIT) && !mem.mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (done_ok || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = accept;
      WAIT:    stall = !done_ok && !timeout_hit;
      default: stall = 1'b0;
    endcase
  end

  // Request register: captured on accept, held stable for the whole WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      req_q   <= 1'b1;
      we_q    <= exmem_write;
      addr_q  <= exmem_addr[ADDR_W+2:3];
      wdata_q <= exmem_wdata << {exmem_addr[2:0], 3'b000};
      wmask_q <= exmem_write ? (lane_mask(exmem_size) << exmem_addr[2:0]) : 8'h00;
      off_q   <= exmem_addr[2:0];
      size_q  <= exmem_size;
      uns_q   <= exmem_unsigned;
      load_q  <= exmem_read;
      rd_q    <= exmem_rd;
      cnt_q   <= '0;
    end else if (done_ok || timeout_hit) begin
      req_q   <= 1'b0;
    end else if (state_q == WAIT) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // MEM/WB register: one-cycle pulse per retired instruction, zero otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_valid_q <= 1'b0;
      readdata_q    <= '0;
      memwb_rd_q    <= '0;
      fault_q       <= 1'b0;
      cause_q       <= '0;
    end else begin
      memwb_valid_q <= 1'b0;
      readdata_q    <= '0;
      memwb_rd_q    <= '0;
      fault_q       <= 1'b0;
      cause_q       <= '0;
      if ((state_q == IDLE) && exmem_valid && !accept) begin
        memwb_valid_q <= 1'b1;
        memwb_rd_q    <= exmem_rd;
        if (illegal) begin
          fault_q <= 1'b1;
          cause_q <= 2'd2;
        end else if (mem_op) begin
          fault_q <= 1'b1;
          cause_q <= 2'd1;
        end
      end else if (done_ok) begin
        memwb_valid_q <= 1'b1;
        memwb_rd_q    <= rd_q;
        readdata_q    <= load_q ?
                         load_extend(mem.mem_rdata >> {off_q, 3'b000}, size_q, uns_q) : 64'd0;
      end else if (timeout_hit) begin
        memwb_valid_q <= 1'b1;
        memwb_rd_q    <= rd_q;
        fault_q       <= 1'b1;
        cause_q       <= 2'd3;
      end
    end
  end

  assign mem.mem_req     = req_q;
  assign mem.mem_we      = we_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wdata   = wdata_q;
  assign mem.mem_wmask   = wmask_q;

  assign memwb_valid    = memwb_valid_q;
  assign memwb_readdata = readdata_q;
  assign memwb_rd       = memwb_rd_q;
  assign fault          = fault_q;
  assign fault_cause    = cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bus and stall checks inline, MEM/WB
// results checked by a scoreboard monitor against hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_valid, exmem_read, exmem_write, exmem_unsigned;
  logic [63:0] exmem_addr, exmem_wdata;
  logic [1:0]  exmem_size;
  logic [4:0]  exmem_rd;
  logic        stall;
  logic        memwb_valid, fault;
  logic [63:0] memwb_readdata;
  logic [4:0]  memwb_rd;
  logic [1:0]  fault_cause;

  load_store_unit_if #(.ADDR_W(8)) bus();

  load_store_unit #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .exmem_valid    (exmem_valid),
    .exmem_read     (exmem_read),
    .exmem_write    (exmem_write),
    .exmem_addr     (exmem_addr),
    .exmem_wdata    (exmem_wdata),
    .exmem_size     (exmem_size),
    .exmem_unsigned (exmem_unsigned),
    .exmem_rd       (exmem_rd),
    .stall          (stall),
    .mem            (bus.master),
    .memwb_valid    (memwb_valid),
    .memwb_readdata (memwb_readdata),
    .memwb_rd       (memwb_rd),
    .fault          (fault),
    .fault_cause    (fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        f;
    logic [1:0]  c;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (memwb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL memwb_unexpected actual rd=%0d data=%h fault=%b cause=%0d required none",
                 memwb_rd, memwb_readdata, fault, fault_cause);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("memwb_readdata", memwb_readdata, e.data);
        chk("memwb_rd", 64'(memwb_rd), 64'(e.rd));
        chk("memwb_fault", 64'(fault), 64'(e.f));
        chk("memwb_cause", 64'(fault_cause), 64'(e.c));
      end
    end
  end

  task automatic drive_idle();
    exmem_valid = 1'b0; exmem_read = 1'b0; exmem_write = 1'b0;
    exmem_addr = '0; exmem_wdata = '0; exmem_size = '0;
    exmem_unsigned = 1'b0; exmem_rd = '0;
  endtask

  task automatic drive_op(input logic rd_n, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] sz,
                          input logic uns, input logic [4:0] rdst);
    exmem_valid = 1'b1; exmem_read = rd_n; exmem_write = wr;
    exmem_addr = addr; exmem_wdata = wdata; exmem_size = sz;
    exmem_unsigned = uns; exmem_rd = rdst;
  endtask

  task automatic do_mem(input logic rd_n, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rdst, input int waitc, input logic [63:0] rdata,
                        input logic [7:0] e_addr, input logic [63:0] e_wdata,
                        input logic [7:0] e_mask, input logic [63:0] e_rdata);
    @(posedge clk); #1;
    drive_op(rd_n, wr, addr, wdata, sz, uns, rdst);
    @(negedge clk);
    chk("stall_accept", 64'(stall), 64'd1);
    chk("req_before_accept", 64'(bus.mem_req), 64'd0);
    exp_q.push_back('{e_rdata, rdst, 1'b0, 2'd0});
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < waitc; i++) begin
      @(negedge clk);
      chk("req_wait", 64'(bus.mem_req), 64'd1);
      chk("stall_wait", 64'(stall), 64'd1);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    chk("req_ready", 64'(bus.mem_req), 64'd1);
    chk("we", 64'(bus.mem_we), 64'(wr));
    chk("addr", 64'(bus.mem_addr), 64'(e_addr));
    chk("wmask", 64'(bus.mem_wmask), 64'(e_mask));
    if (wr) chk("wdata", bus.mem_wdata, e_wdata);
    chk("stall_ready", 64'(stall), 64'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    chk("req_drop", 64'(bus.mem_req), 64'd0);
  endtask

  task automatic do_nonmem(input logic rd_n, input logic wr, input logic [63:0] addr,
                           input logic [1:0] sz, input logic [4:0] rdst,
                           input logic f, input logic [1:0] c);
    @(posedge clk); #1;
    drive_op(rd_n, wr, addr, 64'h1111_2222_3333_4444, sz, 1'b0, rdst);
    @(negedge clk);
    chk("stall_nonmem", 64'(stall), 64'd0);
    exp_q.push_back('{64'd0, rdst, f, c});
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("req_nonmem", 64'(bus.mem_req), 64'd0);
    chk("stall_after_nonmem", 64'(stall), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req", 64'(bus.mem_req), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst_wdata", bus.mem_wdata, 64'd0);
    chk("rst_memwb_valid", 64'(memwb_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // dword store at 0x18, ready in the first request cycle
    do_mem(1'b0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 5'd5, 0, 64'd0,
           8'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'd0);
    // byte load at 0x1D, signed then unsigned
    do_mem(1'b1, 1'b0, 64'h1D, 64'd0, 2'd0, 1'b0, 5'd7, 0, 64'h0000_8000_0000_0000,
           8'd3, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
    do_mem(1'b1, 1'b0, 64'h1D, 64'd0, 2'd0, 1'b1, 5'd8, 2, 64'h0000_8000_0000_0000,
           8'd3, 64'd0, 8'h00, 64'h0000_0000_0000_0080);
    // half store 0x1234 at 0x0A
    do_mem(1'b0, 1'b1, 64'h0A, 64'h1234, 2'd1, 1'b0, 5'd2, 1, 64'd0,
           8'd1, 64'h0000_0000_1234_0000, 8'h0C, 64'd0);
    // word loads at offset 4, unsigned and signed
    do_mem(1'b1, 1'b0, 64'h24, 64'd0, 2'd2, 1'b1, 5'd10, 0, 64'h89AB_CDEF_0123_4567,
           8'd4, 64'd0, 8'h00, 64'h0000_0000_89AB_CDEF);
    do_mem(1'b1, 1'b0, 64'h24, 64'd0, 2'd2, 1'b0, 5'd11, 1, 64'h89AB_CDEF_0123_4567,
           8'd4, 64'd0, 8'h00, 64'hFFFF_FFFF_89AB_CDEF);
    // half load signed at 0x02 and dword load at 0x20
    do_mem(1'b1, 1'b0, 64'h02, 64'd0, 2'd1, 1'b0, 5'd12, 0, 64'h0000_0000_8001_0000,
           8'd0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_8001);
    do_mem(1'b1, 1'b0, 64'h20, 64'd0, 2'd3, 1'b0, 5'd13, 3, 64'h0123_4567_89AB_CDEF,
           8'd4, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
    // byte store at top lane
    do_mem(1'b0, 1'b1, 64'h0F, 64'h0000_0000_0000_00A5, 2'd0, 1'b0, 5'd14, 0, 64'd0,
           8'd1, 64'hA500_0000_0000_0000, 8'h80, 64'd0);

    // misaligned word load, illegal read+write, plain non-memory op
    do_nonmem(1'b1, 1'b0, 64'h06, 2'd2, 5'd6, 1'b1, 2'd1);
    do_nonmem(1'b1, 1'b1, 64'h08, 2'd3, 5'd15, 1'b1, 2'd2);
    do_nonmem(1'b0, 1'b0, 64'h00, 2'd0, 5'd9, 1'b0, 2'd0);

    // timeout: ready withheld for 20 cycles
    @(posedge clk); #1;
    drive_op(1'b0, 1'b1, 64'h10, 64'h0000_0000_A5A5_A5A5, 2'd2, 1'b0, 5'd3);
    @(negedge clk);
    chk("stall_accept_to", 64'(stall), 64'd1);
    exp_q.push_back('{64'd0, 5'd3, 1'b1, 2'd3});
    @(posedge clk); #1;
    drive_idle();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("req_to_wait", 64'(bus.mem_req), 64'd1);
      chk("stall_to_wait", 64'(stall), (k < 15) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("req_after_to", 64'(bus.mem_req), 64'd0);
      chk("stall_after_to", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    // stray ready while idle must be ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // reset during the second WAIT cycle abandons the request
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 64'h01, 64'd0, 2'd0, 1'b0, 5'd4);
    @(negedge clk);
    chk("stall_accept_rst", 64'(stall), 64'd1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("req_rst_wait1", 64'(bus.mem_req), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("req_after_rst", 64'(bus.mem_req), 64'd0);
    chk("wmask_after_rst", 64'(bus.mem_wmask), 64'd0);
    chk("addr_after_rst", 64'(bus.mem_addr), 64'd0);
    chk("memwb_after_rst", 64'(memwb_valid), 64'd0);
    chk("fault_after_rst", 64'(fault), 64'd0);
    chk("stall_after_rst", 64'(stall), 64'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 64'h0000_0000_0000_0080;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
